cacheline_burst_responder: RTL and testbench

Converts the cache hierarchy's line-wide downstream requests into fixed-length bursts on the narrow physical-memory bus. It sits below the last-level cache datapath/controller pair and acts as the responder to that cache's downstream read (line fill) and write (write-back) requests. It returns one assembled line and a single-cycle `line_resp` per request.

---
 rtl/cacheline_burst_responder.sv | 133 +++++++++++++
 tb/tb_cacheline_burst_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_responder.sv
// ============================================================================
// Module   : cacheline_burst_responder
// Purpose  : Turns line-wide cache fill/write-back requests into fixed-length
//            ascending-beat bursts on the narrow memory bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_burst_responder #(
  parameter int S_LINE   = 256,
  parameter int S_BEAT   = 64,
  parameter int S_OFFSET = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_address,
  input  logic [S_LINE-1:0] line_wdata,
  output logic [S_LINE-1:0] line_rdata,
  output logic              line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [S_BEAT-1:0] mem_wdata,
  input  logic [S_BEAT-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int NUM_BEATS = S_LINE / S_BEAT;
  localparam int CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] C_LAST_BEAT  = CW'(NUM_BEATS - 1);
  localparam logic [31:0]   C_ALIGN_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CW-1:0]       r_count;
  logic [31:0]         r_addr;
  logic [S_LINE-1:0]   r_wdata;
  logic [S_LINE-1:0]   r_rdata;
  logic                w_capture;
  logic                w_beat;
  logic                w_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write wins a simultaneous request; the held read is taken on the next IDLE.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_beat       = 1'b0;
    w_store      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    line_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (line_write) begin
          w_next_state = WRITE;
          w_capture    = 1'b1;
        end else if (line_read) begin
          w_next_state = READ;
          w_capture    = 1'b1;
        end
      end
      READ: begin
        mem_read = 1'b1;
        w_beat   = mem_resp;
        w_store  = mem_resp;
        if (mem_resp && (r_count == C_LAST_BEAT)) begin
          w_next_state = DONE;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        w_beat    = mem_resp;
        if (mem_resp && (r_count == C_LAST_BEAT)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        line_resp    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_capture) begin
        r_addr  <= line_address;
        r_count <= '0;
        if (line_write) begin
          r_wdata <= line_wdata;
        end
      end
      if (w_store) begin
        r_rdata[r_count*S_BEAT +: S_BEAT] <= mem_rdata;
      end
      if (w_beat) begin
        r_count <= (r_count == C_LAST_BEAT) ? '0 : r_count + 1'b1;
      end
    end
  end

  assign mem_address = r_addr & C_ALIGN_MASK;
  assign mem_wdata   = r_wdata[r_count*S_BEAT +: S_BEAT];
  assign line_rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cacheline_burst_responder.sv
// ============================================================================
// Module   : tb_cacheline_burst_responder
// Purpose  : Directed checks of fills, write-backs, arbitration and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_burst_responder;

  logic         clk;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int vectors;
  int miscompares;

  cacheline_burst_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_resp"},  256'(line_resp), 256'd0);
    check({tag, "_rd"},    256'(mem_read),  256'd0);
    check({tag, "_wr"},    256'(mem_write), 256'd0);
  endtask

  // Entered at the negedge of the acceptance cycle; returns at the negedge of the line_resp cycle.
  task automatic burst_read(input logic [31:0] exp_addr, input logic [255:0] line, input int waits);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        check("rd_mem_read",  256'(mem_read),    256'd1);
        check("rd_mem_write", 256'(mem_write),   256'd0);
        check("rd_addr",      256'(mem_address), 256'(exp_addr));
        check("rd_no_resp",   256'(line_resp),   256'd0);
        mem_resp  = (w == waits);
        mem_rdata = line[b*64 +: 64];
      end
    end
    @(negedge clk);
    mem_resp = 1'b0;
    check("rd_line_resp", 256'(line_resp), 256'd1);
    check("rd_done_rd",   256'(mem_read),  256'd0);
    check("rd_rdata",     line_rdata,      line);
  endtask

  task automatic burst_write(input logic [31:0] exp_addr, input logic [255:0] line, input int waits,
                             input logic [255:0] keep_rdata);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        check("wr_mem_write", 256'(mem_write),   256'd1);
        check("wr_mem_read",  256'(mem_read),    256'd0);
        check("wr_addr",      256'(mem_address), 256'(exp_addr));
        check("wr_wdata",     256'(mem_wdata),   256'(line[b*64 +: 64]));
        check("wr_no_resp",   256'(line_resp),   256'd0);
        mem_resp = (w == waits);
      end
    end
    @(negedge clk);
    mem_resp = 1'b0;
    check("wr_line_resp", 256'(line_resp), 256'd1);
    check("wr_done_wr",   256'(mem_write), 256'd0);
    check("wr_rdata_kept", line_rdata, keep_rdata);
  endtask

  logic [255:0] l1, l2, l3, l4, l5, w1, w2;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = 32'd0;
    line_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
          64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
    l3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D};
    l4 = {64'h3030_3030_3030_3030, 64'h2020_2020_2020_2020,
          64'h1010_1010_1010_1010, 64'h0F0F_0F0F_0F0F_0F0F};
    l5 = {64'h0000_0000_0000_00DD, 64'h0000_0000_0000_00CC,
          64'h0000_0000_0000_00BB, 64'h0000_0000_0000_00AA};
    w1 = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
          64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    w2 = {64'hE3E3_0000_0000_E3E3, 64'hE2E2_0000_0000_E2E2,
          64'hE1E1_0000_0000_E1E1, 64'hE0E0_0000_0000_E0E0};

    // Reset state
    @(negedge clk);
    check_idle("reset");
    check("reset_addr",  256'(mem_address), 256'd0);
    check("reset_wdata", 256'(mem_wdata),   256'd0);
    check("reset_rdata", line_rdata,        256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Fill, zero-wait memory: line_resp lands in cycle 5
    line_read    = 1'b1;
    line_address = 32'h0000_1234;
    check("fill_c0_rd", 256'(mem_read), 256'd0);
    burst_read(32'h0000_1220, l1, 0);
    @(negedge clk);
    line_read = 1'b0;
    check_idle("fill_c6");
    @(negedge clk);
    check_idle("fill_c7");
    check("fill_hold", line_rdata, l1);

    // Write-back with two wait states per beat: line_resp in cycle 13
    line_write   = 1'b1;
    line_address = 32'h0000_8765;
    line_wdata   = w1;
    burst_write(32'h0000_8760, w1, 2, l1);
    @(negedge clk);
    line_write = 1'b0;
    line_wdata = '0;
    check_idle("wb_after");

    // Simultaneous: write first, then the held read
    line_read    = 1'b1;
    line_write   = 1'b1;
    line_address = 32'h0000_4010;
    line_wdata   = w2;
    burst_write(32'h0000_4000, w2, 0, l1);
    @(negedge clk);
    line_write = 1'b0;
    check_idle("simul_gap");
    burst_read(32'h0000_4000, l2, 1);
    @(negedge clk);
    line_read = 1'b0;
    check_idle("simul_after");

    // Spurious mem_resp in IDLE
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1;
      @(negedge clk);
      check_idle("spurious");
    end
    mem_resp = 1'b0;

    // Back-to-back reads; beat 0 landing low also shows the counter stayed 0
    line_read    = 1'b1;
    line_address = 32'h0000_0100;
    burst_read(32'h0000_0100, l3, 0);
    @(negedge clk);
    line_address = 32'h0000_021F;
    check_idle("b2b_gap");
    burst_read(32'h0000_0200, l4, 0);
    @(negedge clk);
    line_read = 1'b0;
    check_idle("b2b_after");

    // Reset after beat 2 of a read
    line_read    = 1'b1;
    line_address = 32'h0000_3000;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = l5[b*64 +: 64];
    end
    @(negedge clk);
    mem_resp = 1'b0;
    check("rst_pre_rd", 256'(mem_read), 256'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_addr",  256'(mem_address), 256'd0);
    check("rst_wdata", 256'(mem_wdata),   256'd0);
    check("rst_rdata", line_rdata,        256'd0);
    line_read = 1'b0;
    @(negedge clk);
    check_idle("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_released");
    line_read = 1'b1;
    burst_read(32'h0000_3000, l5, 0);
    @(negedge clk);
    line_read = 1'b0;
    check_idle("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
